dbf_scan_ctrl: RTL and testbench
================================

// Module: dbf_scan_ctrl
// PURPOSE
// - Per-line sequencer for the DBF channel array. Drives the shared tx_en, start, dbf_lut_addr and dbf_lut_we.
// - Each scan line runs: transmit window -> dead time -> receive window, in which the coarse/fine delay LUT address is stepped.
// - Counts lines within a frame and reports line and frame completion to the frame-level controller.
// PARAMETERS
// - ADDR_WD     10  width of dbf_lut_addr (matches the channel LUT depth).
// - TX_LEN_WD    8  width of cfg_tx_len.
// - RX_LEN_WD   14  width of cfg_rx_len (receive samples per line).
// - LINE_WD      8  width of cfg_num_lines and line_idx.
// - ADDR_DIV     4  receive samples per LUT address step; must be >=1.
// PORTS
// - clk            in   1          system clock; all logic on the rising edge.
// - rst_n          in   1          one clock; reset is asynchronous and active-high (rst_n=1 resets).
// - frame_start    in   1          pulse: arms a frame of cfg_num_lines lines.
// - line_trig      in   1          pulse: starts the next line when the block is in ARM.
// - abort          in   1          level: terminates the frame immediately.
// - cfg_tx_len     in   TX_LEN_WD  transmit window length in cycles.
// - cfg_dead_len   in   TX_LEN_WD  dead time in cycles (0 allowed).
// - cfg_rx_len     in   RX_LEN_WD  receive window length in cycles.
// - cfg_num_lines  in   LINE_WD    lines per frame.
// - tx_en          out  1          transmit window active.
// - start          out  1          receive/beamform window active.
// - dbf_lut_addr   out  ADDR_WD    delay LUT address, shared by all channels.
// - dbf_lut_we     out  1          LUT access strobe; 1 in each cycle that dbf_lut_addr takes a new value.
// - line_idx       out  LINE_WD    index of the current line.
// - line_done      out  1          1-cycle pulse at the end of each line.
// - frame_done     out  1          1-cycle pulse after the last line.
// - busy           out  1          state != IDLE.
// BEHAVIOUR
// - Reset: state=IDLE. All outputs are 0; all counters are 0.
// - States: IDLE, ARM, TX, DEAD, RX, DONE.
// - IDLE: frame_start latches all cfg_* registers, sets line_idx=0, next state ARM. cfg_* are sampled only here.
// - ARM: line_trig -> TX. line_trig in any other state is ignored.
// - TX: tx_en=1 for exactly max(cfg_tx_len,1) cycles, starting the cycle after line_trig. Then DEAD, or RX directly if cfg_dead_len=0.
// - DEAD: all outputs idle for cfg_dead_len cycles, then RX.
// - RX: start=1 for max(cfg_rx_len,1) cycles.
//   - dbf_lut_addr=0 in the first RX cycle, then +1 every ADDR_DIV cycles.
//   - dbf_lut_addr saturates at 2^ADDR_WD-1 (no wrap).
//   - dbf_lut_we=1 in the first RX cycle and in each increment cycle. No strobe while saturated.
// - DONE (1 cycle): line_done=1.
//   - If line_idx==cfg_num_lines-1: frame_done=1, line_idx returns to 0, next state IDLE.
//   - Otherwise line_idx+=1, next state ARM.
// - cfg_num_lines=0 is treated as 1.
// - tx_en and start are never both 1. dbf_lut_addr returns to 0 when RX is left.
// - abort (highest priority, any state): next cycle state=IDLE and all outputs 0. line_done and frame_done are not pulsed.
// - frame_start while busy=1 is ignored.
// - Simultaneous frame_start and abort in IDLE: abort wins and the block stays in IDLE.
// - Latency: line_trig at cycle t -> tx_en rises at t+1.
//   - Last RX cycle at c -> line_done at c+1.
//   - Next line_trig is accepted from c+2.
// - All outputs are registered.
// CONFIGURATION
// - Macro DBF_OVERRUN_STAT_EN adds outputs overrun_err (1) and overrun_cnt (8).
//   - overrun_err is a sticky flag, set by line_trig arriving while in TX, DEAD, RX or DONE.
//   - overrun_cnt counts those events and saturates at 255.
//   - Both are cleared by reset or by an accepted frame_start.
// - Without the macro: these ports and their logic are absent; a mistimed line_trig is silently dropped.
// TESTING
// 1. Nominal line: tx=3, dead=2, rx=10, lines=1, ADDR_DIV=4, trig at t.
//    -> tx_en t+1..t+3; start t+6..t+15.
//    -> addr 0,1,2 with we at t+6, t+10, t+14; line_done and frame_done at t+16.
// 2. Multi-line frame: lines=3.
//    -> line_idx goes 0,1,2; 3 line_done pulses; 1 frame_done; busy=0 afterwards.
// 3. Zero config: tx=0, dead=0, rx=0, lines=0.
//    -> tx_en for 1 cycle, start the next cycle for 1 cycle, then line_done and frame_done.
// 4. Saturation: ADDR_WD=2, rx=40, ADDR_DIV=4.
//    -> addr sticks at 3 with exactly 4 we strobes.
// 5. abort asserted mid-RX (addr=5).
//    -> next cycle start=0, addr=0, busy=0, no line_done; a new frame_start works normally.
// 6. line_trig during RX.
//    -> ignored; the line completes normally.
//    -> with DBF_OVERRUN_STAT_EN: overrun_err=1, overrun_cnt=1.

Source files
------------

// File: rtl/dbf_scan_ctrl.sv
// dbf_scan_ctrl: per-line scan sequencer for the DBF channel array.
// Each line runs TX window -> dead time -> RX window, stepping the shared
// delay-LUT address during RX, and reports line/frame completion.
// Optional build macro DBF_OVERRUN_STAT_EN adds overrun_err / overrun_cnt,
// which record line_trig pulses arriving while a line is still in flight.
// Note: rst_n is an active-high asynchronous reset despite its name; the
// name is kept for drop-in compatibility with existing instantiations.
module dbf_scan_ctrl #(
  parameter int unsigned ADDR_WD   = 10,
  parameter int unsigned TX_LEN_WD = 8,
  parameter int unsigned RX_LEN_WD = 14,
  parameter int unsigned LINE_WD   = 8,
  parameter int unsigned ADDR_DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 line_trig,
  input  logic                 abort,
  input  logic [TX_LEN_WD-1:0] cfg_tx_len,
  input  logic [TX_LEN_WD-1:0] cfg_dead_len,
  input  logic [RX_LEN_WD-1:0] cfg_rx_len,
  input  logic [LINE_WD-1:0]   cfg_num_lines,
  output logic                 tx_en,
  output logic                 start,
  output logic [ADDR_WD-1:0]   dbf_lut_addr,
  output logic                 dbf_lut_we,
  output logic [LINE_WD-1:0]   line_idx,
  output logic                 line_done,
  output logic                 frame_done,
  output logic                 busy
`ifdef DBF_OVERRUN_STAT_EN
  ,
  output logic                 overrun_err,
  output logic [7:0]           overrun_cnt
`endif
);

  localparam int unsigned CNT_WD = (RX_LEN_WD > TX_LEN_WD) ? RX_LEN_WD : TX_LEN_WD;
  localparam int unsigned DIV_WD = (ADDR_DIV > 1) ? $clog2(ADDR_DIV) : 1;
  localparam logic [DIV_WD-1:0]  DIV_LAST = DIV_WD'(ADDR_DIV - 1);
  localparam logic [ADDR_WD-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_TX, S_DEAD, S_RX, S_DONE
  } state_t;

  state_t               state;
  logic [CNT_WD-1:0]    cnt;
  logic [DIV_WD-1:0]    div_cnt;
  logic [TX_LEN_WD-1:0] cfg_tx_len_q;
  logic [TX_LEN_WD-1:0] cfg_dead_len_q;
  logic [RX_LEN_WD-1:0] cfg_rx_len_q;
  logic [LINE_WD-1:0]   cfg_num_lines_q;

  // cnt holds the number of cycles remaining in the current phase after this one,
  // so a zero length behaves as a single cycle.
  logic [CNT_WD-1:0]  tx_load;
  logic [CNT_WD-1:0]  dead_load;
  logic [CNT_WD-1:0]  rx_load;
  logic [LINE_WD-1:0] lines_last;
  logic               last_line;

  assign tx_load    = (cfg_tx_len_q == '0) ? '0 : CNT_WD'(cfg_tx_len_q - TX_LEN_WD'(1));
  assign dead_load  = CNT_WD'(cfg_dead_len_q - TX_LEN_WD'(1));
  assign rx_load    = (cfg_rx_len_q == '0) ? '0 : CNT_WD'(cfg_rx_len_q - RX_LEN_WD'(1));
  assign lines_last = (cfg_num_lines_q == '0) ? '0 : cfg_num_lines_q - LINE_WD'(1);
  assign last_line  = (line_idx == lines_last);

  // Line sequencer: state, phase counters and all registered outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      div_cnt         <= '0;
      cfg_tx_len_q    <= '0;
      cfg_dead_len_q  <= '0;
      cfg_rx_len_q    <= '0;
      cfg_num_lines_q <= '0;
      tx_en           <= 1'b0;
      start           <= 1'b0;
      dbf_lut_addr    <= '0;
      dbf_lut_we      <= 1'b0;
      line_idx        <= '0;
      line_done       <= 1'b0;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
    end else if (abort) begin
      state        <= S_IDLE;
      cnt          <= '0;
      div_cnt      <= '0;
      tx_en        <= 1'b0;
      start        <= 1'b0;
      dbf_lut_addr <= '0;
      dbf_lut_we   <= 1'b0;
      line_idx     <= '0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dbf_lut_we <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            cfg_tx_len_q    <= cfg_tx_len;
            cfg_dead_len_q  <= cfg_dead_len;
            cfg_rx_len_q    <= cfg_rx_len;
            cfg_num_lines_q <= cfg_num_lines;
            line_idx        <= '0;
            state           <= S_ARM;
            busy            <= 1'b1;
          end
        end
        S_ARM: begin
          if (line_trig) begin
            state <= S_TX;
            tx_en <= 1'b1;
            cnt   <= tx_load;
          end
        end
        S_TX: begin
          if (cnt == '0) begin
            tx_en <= 1'b0;
            if (cfg_dead_len_q == '0) begin
              state        <= S_RX;
              start        <= 1'b1;
              dbf_lut_addr <= '0;
              dbf_lut_we   <= 1'b1;
              div_cnt      <= '0;
              cnt          <= rx_load;
            end else begin
              state <= S_DEAD;
              cnt   <= dead_load;
            end
          end else begin
            cnt <= cnt - CNT_WD'(1);
          end
        end
        S_DEAD: begin
          if (cnt == '0) begin
            state        <= S_RX;
            start        <= 1'b1;
            dbf_lut_addr <= '0;
            dbf_lut_we   <= 1'b1;
            div_cnt      <= '0;
            cnt          <= rx_load;
          end else begin
            cnt <= cnt - CNT_WD'(1);
          end
        end
        S_RX: begin
          if (cnt == '0) begin
            state        <= S_DONE;
            start        <= 1'b0;
            dbf_lut_addr <= '0;
            div_cnt      <= '0;
            line_done    <= 1'b1;
            frame_done   <= last_line;
          end else begin
            cnt <= cnt - CNT_WD'(1);
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              if (dbf_lut_addr != ADDR_MAX) begin
                dbf_lut_addr <= dbf_lut_addr + ADDR_WD'(1);
                dbf_lut_we   <= 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + DIV_WD'(1);
            end
          end
        end
        S_DONE: begin
          if (last_line) begin
            line_idx <= '0;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end else begin
            line_idx <= line_idx + LINE_WD'(1);
            state    <= S_ARM;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DBF_OVERRUN_STAT_EN
  // Overrun statistics: sticky flag and saturating count of mistimed line_trig.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      overrun_err <= 1'b0;
      overrun_cnt <= '0;
    end else if (state == S_IDLE && frame_start && !abort) begin
      overrun_err <= 1'b0;
      overrun_cnt <= '0;
    end else if (line_trig && (state inside {S_TX, S_DEAD, S_RX, S_DONE})) begin
      overrun_err <= 1'b1;
      if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dbf_scan_ctrl.sv
// Directed self-checking bench for dbf_scan_ctrl. A second instance with
// ADDR_WD=2 shares the stimulus and is used for the address saturation case.
module tb_dbf_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, frame_start, line_trig, abort;
  logic [7:0]  cfg_tx_len, cfg_dead_len, cfg_num_lines;
  logic [13:0] cfg_rx_len;

  logic        tx_en, start, dbf_lut_we, line_done, frame_done, busy;
  logic [9:0]  dbf_lut_addr;
  logic [7:0]  line_idx;

  logic        s_tx_en, s_start, s_we, s_line_done, s_frame_done, s_busy;
  logic [1:0]  s_addr;
  logic [7:0]  s_line_idx;

`ifdef DBF_OVERRUN_STAT_EN
  logic        overrun_err, s_overrun_err;
  logic [7:0]  overrun_cnt, s_overrun_cnt;
`endif

  int total = 0;
  int bad   = 0;

  dbf_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_trig(line_trig),
    .abort(abort), .cfg_tx_len(cfg_tx_len), .cfg_dead_len(cfg_dead_len),
    .cfg_rx_len(cfg_rx_len), .cfg_num_lines(cfg_num_lines),
    .tx_en(tx_en), .start(start), .dbf_lut_addr(dbf_lut_addr), .dbf_lut_we(dbf_lut_we),
    .line_idx(line_idx), .line_done(line_done), .frame_done(frame_done), .busy(busy)
`ifdef DBF_OVERRUN_STAT_EN
    , .overrun_err(overrun_err), .overrun_cnt(overrun_cnt)
`endif
  );

  dbf_scan_ctrl #(.ADDR_WD(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_trig(line_trig),
    .abort(abort), .cfg_tx_len(cfg_tx_len), .cfg_dead_len(cfg_dead_len),
    .cfg_rx_len(cfg_rx_len), .cfg_num_lines(cfg_num_lines),
    .tx_en(s_tx_en), .start(s_start), .dbf_lut_addr(s_addr), .dbf_lut_we(s_we),
    .line_idx(s_line_idx), .line_done(s_line_done), .frame_done(s_frame_done), .busy(s_busy)
`ifdef DBF_OVERRUN_STAT_EN
    , .overrun_err(s_overrun_err), .overrun_cnt(s_overrun_cnt)
`endif
  );

  // {tx_en, start, we, line_done, frame_done, busy, line_idx, addr}
  logic [23:0] obs;
  assign obs = {tx_en, start, dbf_lut_we, line_done, frame_done, busy, line_idx, dbf_lut_addr};

  function automatic logic [23:0] pack(bit tx, bit st, bit we, bit ld, bit fd, bit bz,
                                       int idx, int addr);
    logic [7:0] i8;
    logic [9:0] a10;
    i8  = 8'(idx);
    a10 = 10'(addr);
    return {tx, st, we, ld, fd, bz, i8, a10};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int tx, input int dead, input int rx, input int lines);
    cfg_tx_len    = 8'(tx);
    cfg_dead_len  = 8'(dead);
    cfg_rx_len    = 14'(rx);
    cfg_num_lines = 8'(lines);
    frame_start   = 1'b1;
    tick();
    frame_start   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (obs !== 24'h0 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_held got=%h want=%h", obs, 24'h0);
    end
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if (obs !== 24'h0) begin
      bad++;
      $display("FAIL reset_released got=%h want=%h", obs, 24'h0);
    end
`ifdef DBF_OVERRUN_STAT_EN
    total++;
    if ({overrun_err, overrun_cnt} !== 9'h0) begin
      bad++;
      $display("FAIL reset_overrun got=%b/%0d want=0/0", overrun_err, overrun_cnt);
    end
`endif
  endtask

  // tx=3 dead=2 rx=10 lines=1, cfg inputs scrambled after the frame is armed.
  task automatic test_nominal();
    logic [23:0] exp;
    int ad;
    start_frame(3, 2, 10, 1);
    total++;
    if (obs !== pack(0, 0, 0, 0, 0, 1, 0, 0)) begin
      bad++;
      $display("FAIL nominal_arm got=%h want=%h", obs, pack(0, 0, 0, 0, 0, 1, 0, 0));
    end
    cfg_tx_len = 8'hFF; cfg_dead_len = 8'hFF; cfg_rx_len = 14'h3FFF; cfg_num_lines = 8'd9;
    line_trig = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) line_trig = 1'b0;
      ad  = (k >= 6 && k <= 15) ? (k - 6) / 4 : 0;
      exp = pack(k >= 1 && k <= 3, k >= 6 && k <= 15, k == 6 || k == 10 || k == 14,
                 k == 16, k == 16, k <= 16, 0, ad);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL nominal t+%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  // Three lines of tx=1 dead=0 rx=2; each next trigger issued at c+2.
  task automatic test_multi_line();
    logic [23:0] exp;
    int ld_cnt = 0;
    int fd_cnt = 0;
    start_frame(1, 0, 2, 3);
    for (int ln = 0; ln < 3; ln++) begin
      line_trig = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (k == 1) line_trig = 1'b0;
        if (line_done === 1'b1) ld_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        exp = pack(k == 1, k == 2 || k == 3, k == 2, k == 4, k == 4 && ln == 2, 1, ln, 0);
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL multi line%0d t+%0d got=%h want=%h", ln, k, obs, exp);
        end
      end
      tick();
      exp = pack(0, 0, 0, 0, 0, ln < 2, (ln < 2) ? ln + 1 : 0, 0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL multi after_line%0d got=%h want=%h", ln, obs, exp);
      end
    end
    total++;
    if (ld_cnt != 3 || fd_cnt != 1) begin
      bad++;
      $display("FAIL multi_pulses got=%0d/%0d want=3/1", ld_cnt, fd_cnt);
    end
  endtask

  task automatic test_zero_cfg();
    logic [23:0] exp;
    start_frame(0, 0, 0, 0);
    line_trig = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) line_trig = 1'b0;
      exp = pack(k == 1, k == 2, k == 2, k == 3, k == 3, k <= 3, 0, 0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL zero_cfg t+%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  // ADDR_WD=2 instance: addr climbs 0..3 then holds; exactly 4 strobes.
  task automatic test_saturation();
    int we_cnt = 0;
    int idx, ea;
    bit ew, es;
    logic [1:0] ea2;
    start_frame(1, 0, 40, 1);
    line_trig = 1'b1;
    for (int k = 1; k <= 43; k++) begin
      tick();
      if (k == 1) line_trig = 1'b0;
      if (s_we === 1'b1) we_cnt++;
      es = (k >= 2 && k <= 41);
      if (es) begin
        idx = k - 2;
        ea  = (idx / 4 > 3) ? 3 : idx / 4;
        ew  = (idx % 4 == 0) && (idx / 4 <= 3);
      end else begin
        ea = 0;
        ew = 1'b0;
      end
      ea2 = 2'(ea);
      total++;
      if ({s_start, s_we, s_addr, s_line_done} !== {es, ew, ea2, k == 42}) begin
        bad++;
        $display("FAIL saturation t+%0d got=%b%b%0d%b want=%b%b%0d%b", k,
                 s_start, s_we, s_addr, s_line_done, es, ew, ea2, k == 42);
      end
    end
    total++;
    if (we_cnt != 4) begin
      bad++;
      $display("FAIL saturation_strobes got=%0d want=4", we_cnt);
    end
  endtask

  task automatic test_abort();
    logic [23:0] exp;
    start_frame(1, 0, 100, 2);
    line_trig = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 1) line_trig = 1'b0;
    end
    total++;
    if (obs !== pack(0, 1, 1, 0, 0, 1, 0, 5)) begin
      bad++;
      $display("FAIL abort_pre got=%h want=%h", obs, pack(0, 1, 1, 0, 0, 1, 0, 5));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs !== 24'h0) begin
        bad++;
        $display("FAIL abort_post c%0d got=%h want=%h", k, obs, 24'h0);
      end
      tick();
    end
    // frame_start and abort together in IDLE: stay idle
    cfg_num_lines = 8'd1;
    frame_start = 1'b1;
    abort = 1'b1;
    tick();
    frame_start = 1'b0;
    abort = 1'b0;
    tick();
    total++;
    if (obs !== 24'h0) begin
      bad++;
      $display("FAIL abort_vs_start got=%h want=%h", obs, 24'h0);
    end
    // a fresh frame still runs normally
    start_frame(1, 0, 2, 1);
    line_trig = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) line_trig = 1'b0;
      exp = pack(k == 1, k == 2 || k == 3, k == 2, k == 4, k == 4, k <= 4, 0, 0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL abort_restart t+%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  // Stray line_trig and frame_start mid-line are ignored.
  task automatic test_trig_during_rx();
    logic [23:0] exp;
    int ad;
    start_frame(2, 1, 6, 1);
    line_trig = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      line_trig = (k == 5);
      frame_start = (k == 6);
      if (k == 6) begin
        cfg_tx_len = 8'd9; cfg_rx_len = 14'd1; cfg_num_lines = 8'd4;
      end
      ad  = (k >= 4 && k <= 9) ? (k - 4) / 4 : 0;
      exp = pack(k <= 2, k >= 4 && k <= 9, k == 4 || k == 8, k == 10, k == 10, k <= 10, 0, ad);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL trig_in_rx t+%0d got=%h want=%h", k, obs, exp);
      end
    end
    line_trig = 1'b0;
    frame_start = 1'b0;
`ifdef DBF_OVERRUN_STAT_EN
    total++;
    if ({overrun_err, overrun_cnt} !== {1'b1, 8'd1}) begin
      bad++;
      $display("FAIL overrun_set got=%b/%0d want=1/1", overrun_err, overrun_cnt);
    end
    start_frame(1, 0, 1, 1);
    total++;
    if ({overrun_err, overrun_cnt} !== 9'h0) begin
      bad++;
      $display("FAIL overrun_clear got=%b/%0d want=0/0", overrun_err, overrun_cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif
  endtask

  initial begin
    rst_n = 1'b1;
    frame_start = 1'b0;
    line_trig = 1'b0;
    abort = 1'b0;
    cfg_tx_len = '0;
    cfg_dead_len = '0;
    cfg_rx_len = '0;
    cfg_num_lines = '0;
    test_reset();
    test_nominal();
    test_multi_line();
    test_zero_cfg();
    test_saturation();
    test_abort();
    test_trig_during_rx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
